mem_arb: RTL and testbench
==========================

# mem_arb

Two-port arbiter sharing the single-port data memory between the multi-cycle CPU controller (port 0) and a DMA/debug loader (port 1). It sits between the requesters and the data-memory array, serialises their accesses, and returns read data with a one-cycle acknowledge. Each access takes a fixed three-state sequence, so CPU memory-state timing stays deterministic whenever the loader is idle.

## Interface
- AW, default 10: word-address width into data memory.
- DW, default 32: data width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  access request; held high until ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_bmode, m1_bmode  in  1  byte mode, passed to memory unchanged.
- m0_addr, m1_addr  in  AW  address.
- m0_wd, m1_wd  in  DW  write data.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rd, m1_rd  out  DW  read data; valid in the ack cycle and held until the next ack to that port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_bmode  out  1  byte mode to memory.
- mem_addr  out  AW  memory address.
- mem_wd  out  DW  memory write data.
- mem_rd  in  DW  memory read data, valid one cycle after mem_en.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req is high, choose a winner, latch its we, bmode, addr, and wd into internal registers plus an owner bit, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive mem_en=1, mem_we=latched we, and latched addr, wd, and bmode. Go to RESP.
- RESP: mem_en=0 and mem_we=0. Capture mem_rd into the owner's rd register on a read; leave it unchanged on a write. Pulse the owner's ack. Go to IDLE.
- Requester rule: sample ack. Drop req, or present the next request, in the cycle after ack. A req still high in IDLE is treated as a new request.
- req dropped during ACCESS or RESP: the transaction still completes and ack still pulses.
- Requester signals are sampled only in IDLE. Changes afterwards are ignored.
- Only one ack is high at a time. An ack never pulses to a port that is not the owner.
- Arbitration when both req are high in IDLE is set by the configuration macro below. A single requester always wins immediately.
- Memory outputs are 0 whenever the state is not ACCESS, except mem_addr, mem_wd, and mem_bmode, which hold their latched values.

## Timing
- Reset values: state IDLE; all outputs 0; rd registers 0; last-grant pointer = 1.
- Reset is asynchronous. Reset asserted mid-transaction forces mem_we low immediately, returns the state to IDLE, and suppresses the pending ack. A write in flight may or may not have completed.
- Latency: req seen high at edge N (state IDLE), mem_en high during cycle N+1, ack high during cycle N+2.
- Throughput: one access per 3 cycles. Back-to-back requests alternate or repeat per arbitration, with no idle bubble other than the IDLE cycle.
- busy is high during ACCESS and RESP only.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration. On a conflict the port other than the last-granted one wins, and the pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, port 0 (CPU) always wins a conflict. The pointer register is not built.

## Structure
- Package mem_arb_pkg: state encoding constants (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2) and port index constants (PORT_CPU=0, PORT_DMA=1).
- One sub-module, arb_pick2: combinational two-way winner selection from the two req bits and the last-grant pointer. Contains the round-robin/fixed-priority choice under MEM_ARB_RR_EN.
- The FSM, latch registers, and rd registers live in mem_arb.

## Test plan
- Single read: m0 reads addr 0x004 with memory word 0xDEADBEEF. Required: mem_en at N+1, m0_ack at N+2, m0_rd=0xDEADBEEF, m1_ack never high.
- Single write: m1 writes 0x12345678 to addr 0x010 with bmode=1. Required: in ACCESS, mem_we=1, mem_addr=0x010, mem_wd=0x12345678, mem_bmode=1. m1_ack at N+2.
- Conflict: both ports request continuously for 4 transactions.
  - Fixed priority (macro undefined): acks to m0, m0, m0, m0.
  - Round-robin (macro defined): acks to m0, m1, m0, m1.
- Request withdrawal: m1 drops req during ACCESS. Required: m1_ack still pulses at N+2, then the state returns to IDLE with busy=0.
- Reset mid-operation: assert rst during ACCESS of an m0 write. Required: mem_we low in the same cycle, no m0_ack, and every output 0 after reset releases.
- Read-data hold: m0 reads 0xCAFEF00D, then m1 reads 0x00000001. Required: m0_rd stays 0xCAFEF00D through m1's transaction.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared state encoding and port indices for the data-memory arbiter.
// Imported by arb_pick2 and mem_arb.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way winner selection for mem_arb.
// MEM_ARB_RR_EN selects round-robin, otherwise port 0 has fixed priority.
module arb_pick2
    import mem_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
`ifdef MEM_ARB_RR_EN
    input  logic i_last,
`endif
    output logic o_any,
    output logic o_win
);

    always_comb begin
        o_any = i_req0 | i_req1;
        o_win = PORT_CPU;
        if (i_req0 && i_req1) begin
`ifdef MEM_ARB_RR_EN
            o_win = ~i_last;
`else
            o_win = PORT_CPU;
`endif
        end else if (i_req1) begin
            o_win = PORT_DMA;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter for the single-port data memory (CPU=port 0, loader=port 1).
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic          m0_bmode,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wd,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rd,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic          m1_bmode,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wd,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rd,
    output logic          mem_en,
    output logic          mem_we,
    output logic          mem_bmode,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);

    state_t        r_state;
    state_t        w_next;
    logic          r_owner;
    logic          r_we;
    logic          r_bmode;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wd;
    logic [DW-1:0] r_rd0;
    logic [DW-1:0] r_rd1;
    logic          w_any;
    logic          w_win;
    logic          w_grant;
    logic          w_cap0;
    logic          w_cap1;

`ifdef MEM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= PORT_DMA;
        end else if (w_grant) begin
            r_last <= w_win;
        end
    end
`endif

    arb_pick2 u_pick (
        .i_req0 (m0_req),
        .i_req1 (m1_req),
`ifdef MEM_ARB_RR_EN
        .i_last (r_last),
`endif
        .o_any  (w_any),
        .o_win  (w_win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        m0_ack  = 1'b0;
        m1_ack  = 1'b0;
        w_cap0  = 1'b0;
        w_cap1  = 1'b0;
        busy    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next  = ACCESS;
                    w_grant = 1'b1;
                end
            end
            ACCESS: begin
                busy   = 1'b1;
                mem_en = 1'b1;
                mem_we = r_we;
                w_next = RESP;
            end
            RESP: begin
                busy   = 1'b1;
                m0_ack = (r_owner == PORT_CPU);
                m1_ack = (r_owner == PORT_DMA);
                w_cap0 = m0_ack & ~r_we;
                w_cap1 = m1_ack & ~r_we;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Requester signals are captured only on the grant edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= PORT_CPU;
            r_we    <= 1'b0;
            r_bmode <= 1'b0;
            r_addr  <= '0;
            r_wd    <= '0;
        end else if (w_grant) begin
            r_owner <= w_win;
            r_we    <= w_win ? m1_we    : m0_we;
            r_bmode <= w_win ? m1_bmode : m0_bmode;
            r_addr  <= w_win ? m1_addr  : m0_addr;
            r_wd    <= w_win ? m1_wd    : m0_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd0 <= '0;
            r_rd1 <= '0;
        end else begin
            if (w_cap0) r_rd0 <= mem_rd;
            if (w_cap1) r_rd1 <= mem_rd;
        end
    end

    // Bypass so read data is already visible in the ack cycle.
    assign m0_rd     = w_cap0 ? mem_rd : r_rd0;
    assign m1_rd     = w_cap1 ? mem_rd : r_rd1;
    assign mem_bmode = r_bmode;
    assign mem_addr  = r_addr;
    assign mem_wd    = r_wd;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb with a behavioural data memory.
// Expected acks and memory accesses are queued by stimulus, checked by a monitor.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_bmode;
    logic [9:0]  m0_addr;
    logic [31:0] m0_wd;
    logic        m0_ack;
    logic [31:0] m0_rd;
    logic        m1_req, m1_we, m1_bmode;
    logic [9:0]  m1_addr;
    logic [31:0] m1_wd;
    logic        m1_ack;
    logic [31:0] m1_rd;
    logic        mem_en, mem_we, mem_bmode;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        port;
        logic        chk;
        logic [31:0] rd;
    } ack_t;

    typedef struct {
        logic        we;
        logic        bm;
        logic [9:0]  addr;
        logic [31:0] wd;
    } acc_t;

    ack_t exp_ack[$];
    acc_t exp_mem[$];

    logic [31:0] tb_mem [0:1023];
    logic        hold_en = 1'b0;
    logic [31:0] hold_val;

    always #5 clk = ~clk;

    mem_arb #(.AW(10), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_bmode(m0_bmode),
        .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_ack(m0_ack), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_bmode(m1_bmode),
        .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_ack(m1_ack), .m1_rd(m1_rd),
        .mem_en(mem_en), .mem_we(mem_we), .mem_bmode(mem_bmode),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .busy(busy)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wd;
            mem_rd <= tb_mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m0_ack && m1_ack) check("dual_ack", 1, 0);
            if (m0_ack || m1_ack) begin
                if (exp_ack.size() == 0) begin
                    check("unexp_ack", {m1_ack, m0_ack}, 0);
                end else begin
                    ack_t a;
                    a = exp_ack.pop_front();
                    check("ack_port", m1_ack, a.port);
                    if (a.chk) check("ack_rd", a.port ? m1_rd : m0_rd, a.rd);
                end
            end
            if (mem_en) begin
                if (exp_mem.size() == 0) begin
                    check("unexp_mem", mem_en, 0);
                end else begin
                    acc_t e;
                    e = exp_mem.pop_front();
                    check("mem_we", mem_we, e.we);
                    check("mem_bmode", mem_bmode, e.bm);
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wd", mem_wd, e.wd);
                end
            end
            if (hold_en) check("m0_rd_hold", m0_rd, hold_val);
        end
    end

    task automatic drive(input logic p, input logic req, input logic we,
                         input logic bm, input logic [9:0] addr,
                         input logic [31:0] wd);
        if (p) begin
            m1_req = req; m1_we = we; m1_bmode = bm;
            m1_addr = addr; m1_wd = wd;
        end else begin
            m0_req = req; m0_we = we; m0_bmode = bm;
            m0_addr = addr; m0_wd = wd;
        end
    endtask

    task automatic push(input logic p, input logic we, input logic bm,
                        input logic [9:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd);
        exp_mem.push_back('{we: we, bm: bm, addr: addr, wd: wd});
        exp_ack.push_back('{port: p, chk: !we, rd: rd});
    endtask

    // Called #1 after a clock edge with the arbiter idle.
    task automatic access(input logic p, input logic we, input logic bm,
                          input logic [9:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input bit drop_early);
        push(p, we, bm, addr, wd, rd);
        drive(p, 1'b1, we, bm, addr, wd);
        @(posedge clk); #1;
        if (drop_early) drive(p, 1'b0, we, bm, addr, wd);
        check("lat_en", mem_en, 1);
        check("busy_acc", busy, 1);
        @(posedge clk); #1;
        check("lat_ack", p ? m1_ack : m0_ack, 1);
        check("other_ack", p ? m0_ack : m1_ack, 0);
        @(posedge clk); #1;
        drive(p, 1'b0, we, bm, addr, wd);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
        tb_mem[10'h004] = 32'hDEADBEEF;
        tb_mem[10'h020] = 32'h000000A0;
        tb_mem[10'h021] = 32'h000000B1;
        tb_mem[10'h030] = 32'h33333333;
        tb_mem[10'h050] = 32'hCAFEF00D;
        tb_mem[10'h051] = 32'h00000001;
        rst = 1'b1;
        drive(1'b0, 0, 0, 0, 10'h0, 32'h0);
        drive(1'b1, 0, 0, 0, 10'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", |{m0_ack, m1_ack, m0_rd, m1_rd, mem_en, mem_we,
                            mem_bmode, mem_addr, mem_wd, busy}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single read on the CPU port
        access(1'b0, 0, 0, 10'h004, 32'h0, 32'hDEADBEEF, 0);
        // Single byte-mode write on the loader port
        access(1'b1, 1, 1, 10'h010, 32'h12345678, 32'h0, 0);

        // Both ports requesting continuously for four transactions
        drive(1'b0, 1, 0, 0, 10'h020, 32'h0);
        drive(1'b1, 1, 0, 0, 10'h021, 32'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            if (k % 2 == 1) push(1'b1, 0, 0, 10'h021, 32'h0, 32'h000000B1);
            else            push(1'b0, 0, 0, 10'h020, 32'h0, 32'h000000A0);
`else
            push(1'b0, 0, 0, 10'h020, 32'h0, 32'h000000A0);
`endif
        end
        repeat (12) @(posedge clk);
        #1;
        drive(1'b0, 0, 0, 0, 10'h0, 32'h0);
        drive(1'b1, 0, 0, 0, 10'h0, 32'h0);
        check("conflict_drain", exp_ack.size(), 0);

        // Loader withdraws its request during ACCESS
        access(1'b1, 0, 0, 10'h030, 32'h0, 32'h33333333, 1);
        @(posedge clk); #1;
        check("withdraw_idle", busy, 0);

        // Reset in the middle of a CPU write
        drive(1'b0, 1, 1, 0, 10'h040, 32'h00000055);
        @(posedge clk); #1;
        check("rst_acc_we", mem_we, 1);
        rst = 1'b1;
        #1;
        check("rst_we_async", mem_we, 0);
        check("rst_en_async", mem_en, 0);
        drive(1'b0, 0, 0, 0, 10'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release_outs", |{m0_ack, m1_ack, m0_rd, m1_rd, mem_en,
                                    mem_we, mem_bmode, mem_addr, mem_wd,
                                    busy}, 0);
        @(posedge clk); #1;

        // CPU read data must hold across a loader read
        access(1'b0, 0, 0, 10'h050, 32'h0, 32'hCAFEF00D, 0);
        hold_val = 32'hCAFEF00D;
        hold_en  = 1'b1;
        access(1'b1, 0, 0, 10'h051, 32'h0, 32'h00000001, 0);
        hold_en  = 1'b0;
        check("m1_rd_final", m1_rd, 32'h00000001);

        repeat (3) @(posedge clk);
        #1;
        check("ack_q_empty", exp_ack.size(), 0);
        check("mem_q_empty", exp_mem.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
